ee_seq: RTL and testbench

- EEPROM access sequencer between the risc4b core's simple request interface and the EEPROM macro pins (WR/RD/ERASE strobes, address, write data, read data).
- Turns a single-cycle command into a correctly timed strobe sequence: erase, program (erase then write) or read. Holds address and data stable for the whole access.
- Reports busy, done and read data back to the core.

---
 rtl/ee_seq.sv | 205 ++++++++++++++++++++
 tb/tb_ee_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ee_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ee_seq : EEPROM access sequencer (erase / program / read strobes).    |
// | Build option EE_SEQ_VERIFY_EN adds a read-back verify after PROGRAM.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module ee_seq #(
   parameter int T_ERASE = 16,
   parameter int T_WRITE = 16,
   parameter int T_READ  = 2
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic       req,
   input  logic [1:0] cmd,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdata,
   output logic       err,
   output logic [3:0] ee_ctrl,
   output logic [7:0] ee_addr,
   output logic [7:0] ee_wdata,
   input  logic [7:0] ee_rdata
);

   localparam int c_T_MAX = (T_ERASE > T_WRITE) ? ((T_ERASE > T_READ) ? T_ERASE : T_READ)
                                                : ((T_WRITE > T_READ) ? T_WRITE : T_READ);
   localparam int c_CW = $clog2(c_T_MAX) + 1;

   localparam logic [c_CW-1:0] c_CNT_ERASE = c_CW'(T_ERASE);
   localparam logic [c_CW-1:0] c_CNT_WRITE = c_CW'(T_WRITE);
   localparam logic [c_CW-1:0] c_CNT_READ  = c_CW'(T_READ);
   localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);

   localparam logic [1:0] c_CMD_NOP  = 2'b00;
   localparam logic [1:0] c_CMD_READ = 2'b01;
   localparam logic [1:0] c_CMD_PROG = 2'b10;

   localparam logic [3:0] c_ST_IDLE  = 4'd0;
   localparam logic [3:0] c_ST_SETUP = 4'd1;
   localparam logic [3:0] c_ST_ERASE = 4'd2;
   localparam logic [3:0] c_ST_GAP   = 4'd3;
   localparam logic [3:0] c_ST_WRITE = 4'd4;
   localparam logic [3:0] c_ST_RD    = 4'd5;
   localparam logic [3:0] c_ST_DONE  = 4'd6;
`ifdef EE_SEQ_VERIFY_EN
   localparam logic [3:0] c_ST_VGAP  = 4'd7;
   localparam logic [3:0] c_ST_VRD   = 4'd8;
`endif

   logic [3:0]      r_state;
   logic [3:0]      w_state_nxt;
   logic [c_CW-1:0] r_cnt;
   logic [c_CW-1:0] w_cnt_nxt;
   logic [1:0]      r_cmd;
   logic [7:0]      r_ee_addr;
   logic [7:0]      r_ee_wdata;
   logic [7:0]      r_rdata;
   logic            r_busy;
   logic            r_done;
   logic [2:0]      r_ctrl;
   logic            w_busy_nxt;
   logic            w_done_nxt;
   logic [2:0]      w_ctrl_nxt;
   logic            w_accept;
   logic            w_cnt_last;
   logic            w_rd_last;

   assign w_accept   = (r_state == c_ST_IDLE) && req && (cmd != c_CMD_NOP);
   assign w_cnt_last = (r_cnt == c_CNT_ONE);
`ifdef EE_SEQ_VERIFY_EN
   assign w_rd_last  = w_cnt_last && ((r_state == c_ST_RD) || (r_state == c_ST_VRD));
`else
   assign w_rd_last  = w_cnt_last && (r_state == c_ST_RD);
`endif

   // State register; strobe outputs are registered from the next state so the
   // async reset drops them immediately.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state <= c_ST_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ctrl  <= 3'b000;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_ctrl  <= w_ctrl_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         c_ST_IDLE:  if (w_accept) w_state_nxt = c_ST_SETUP;
         c_ST_SETUP: begin
            if (r_cmd == c_CMD_READ) begin
               w_state_nxt = c_ST_RD;
               w_cnt_nxt   = c_CNT_READ;
            end else begin
               w_state_nxt = c_ST_ERASE;
               w_cnt_nxt   = c_CNT_ERASE;
            end
         end
         c_ST_ERASE: begin
            if (w_cnt_last) w_state_nxt = (r_cmd == c_CMD_PROG) ? c_ST_GAP : c_ST_DONE;
            else            w_cnt_nxt   = r_cnt - c_CNT_ONE;
         end
         c_ST_GAP: begin
            w_state_nxt = c_ST_WRITE;
            w_cnt_nxt   = c_CNT_WRITE;
         end
         c_ST_WRITE: begin
`ifdef EE_SEQ_VERIFY_EN
            if (w_cnt_last) w_state_nxt = c_ST_VGAP;
`else
            if (w_cnt_last) w_state_nxt = c_ST_DONE;
`endif
            else            w_cnt_nxt   = r_cnt - c_CNT_ONE;
         end
`ifdef EE_SEQ_VERIFY_EN
         c_ST_VGAP: begin
            w_state_nxt = c_ST_VRD;
            w_cnt_nxt   = c_CNT_READ;
         end
         c_ST_VRD: begin
            if (w_cnt_last) w_state_nxt = c_ST_DONE;
            else            w_cnt_nxt   = r_cnt - c_CNT_ONE;
         end
`endif
         c_ST_RD: begin
            if (w_cnt_last) w_state_nxt = c_ST_DONE;
            else            w_cnt_nxt   = r_cnt - c_CNT_ONE;
         end
         c_ST_DONE:  w_state_nxt = c_ST_IDLE;
         default:    w_state_nxt = c_ST_IDLE;
      endcase
   end

   // ctrl bit order: [0] WR, [1] RD, [2] ERASE
   always_comb begin
      w_busy_nxt = (w_state_nxt != c_ST_IDLE);
      w_done_nxt = (w_state_nxt == c_ST_DONE);
      w_ctrl_nxt = 3'b000;
      case (w_state_nxt)
         c_ST_ERASE: w_ctrl_nxt = 3'b100;
         c_ST_WRITE: w_ctrl_nxt = 3'b001;
         c_ST_RD:    w_ctrl_nxt = 3'b010;
`ifdef EE_SEQ_VERIFY_EN
         c_ST_VRD:   w_ctrl_nxt = 3'b010;
`endif
         default:    w_ctrl_nxt = 3'b000;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_cmd      <= c_CMD_NOP;
         r_ee_addr  <= 8'h00;
         r_ee_wdata <= 8'h00;
         r_rdata    <= 8'h00;
      end else begin
         if (w_accept) begin
            r_cmd      <= cmd;
            r_ee_addr  <= addr;
            r_ee_wdata <= wdata;
         end
         if (w_rd_last) r_rdata <= ee_rdata;
      end
   end

`ifdef EE_SEQ_VERIFY_EN
   logic r_err;

   // Sticky until the next accepted command.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_err <= 1'b0;
      end else if (w_accept) begin
         r_err <= 1'b0;
      end else if (w_cnt_last && (r_state == c_ST_VRD) && (ee_rdata != r_ee_wdata)) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   assign busy     = r_busy;
   assign done     = r_done;
   assign rdata    = r_rdata;
   assign ee_ctrl  = {1'b0, r_ctrl};
   assign ee_addr  = r_ee_addr;
   assign ee_wdata = r_ee_wdata;

endmodule
`default_nettype wire

// File: tb/tb_ee_seq.sv
`default_nettype none
// tb_ee_seq: directed bench for ee_seq with a timeline model of the expected pins.
module tb_ee_seq;

   localparam int T_ERASE = 4;
   localparam int T_WRITE = 4;
   localparam int T_READ  = 2;
`ifdef EE_SEQ_VERIFY_EN
   localparam int EXP_PROG_DONE = 14;
   localparam int EXP_PROG_RD   = 12;
`else
   localparam int EXP_PROG_DONE = 11;
   localparam int EXP_PROG_RD   = -1;
`endif

   logic       clk = 1'b0;
   logic       nreset = 1'b0;
   logic       req = 1'b0;
   logic [1:0] cmd = 2'b00;
   logic [7:0] addr = 8'h00;
   logic [7:0] wdata = 8'h00;
   logic       busy, done, err;
   logic [7:0] rdata, ee_addr, ee_wdata, ee_rdata;
   logic [3:0] ee_ctrl;

   ee_seq #(.T_ERASE(T_ERASE), .T_WRITE(T_WRITE), .T_READ(T_READ)) dut (
      .clk(clk), .nreset(nreset), .req(req), .cmd(cmd), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .rdata(rdata), .err(err), .ee_ctrl(ee_ctrl),
      .ee_addr(ee_addr), .ee_wdata(ee_wdata), .ee_rdata(ee_rdata)
   );

   initial forever #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // EEPROM macro: erase sets 0xFF, write stores data through a stuck-bit mask.
   logic [7:0] mem [256];
   logic [7:0] ref_mem [256];
   logic [7:0] wr_mask = 8'hFF;
   assign ee_rdata = ee_ctrl[1] ? mem[ee_addr] : 8'h00;

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i] = 8'h00;
         ref_mem[i] = 8'h00;
      end
      forever begin
         @(posedge clk);
         if (ee_ctrl[2])      mem[ee_addr] = 8'hFF;
         else if (ee_ctrl[0]) mem[ee_addr] = ee_wdata & wr_mask;
      end
   end

   // Model: each accepted command expands into a per-cycle list of expected pins.
   typedef struct packed {
      logic       busy;
      logic       done;
      logic [2:0] ctrl;
      logic [7:0] rdata;
      logic       err;
   } exp_t;

   exp_t       q[$];
   exp_t       cur = '0;
   logic [7:0] m_rdata = 8'h00;
   logic       m_err = 1'b0;
   logic [7:0] m_addr = 8'h00;
   logic [7:0] m_wdata = 8'h00;

   function automatic void push(input int n, input logic [2:0] c);
      for (int i = 0; i < n; i++) q.push_back('{1'b1, 1'b0, c, m_rdata, m_err});
   endfunction

   function automatic void model_accept(input logic [1:0] c, input logic [7:0] a, input logic [7:0] d);
      m_err   = 1'b0;
      m_addr  = a;
      m_wdata = d;
      push(1, 3'b000);
      case (c)
         2'b01: begin
            push(T_READ, 3'b010);
            m_rdata = ref_mem[a];
         end
         2'b11: begin
            push(T_ERASE, 3'b100);
            ref_mem[a] = 8'hFF;
         end
         default: begin
            push(T_ERASE, 3'b100);
            push(1, 3'b000);
            push(T_WRITE, 3'b001);
            ref_mem[a] = d & wr_mask;
`ifdef EE_SEQ_VERIFY_EN
            push(1, 3'b000);
            push(T_READ, 3'b010);
            m_rdata = ref_mem[a];
            m_err   = (ref_mem[a] != d);
`endif
         end
      endcase
      q.push_back('{1'b1, 1'b1, 3'b000, m_rdata, m_err});
   endfunction

   initial forever begin
      @(posedge clk or negedge nreset);
      if (!nreset) begin
         q.delete();
         m_rdata = 8'h00; m_err = 1'b0; m_addr = 8'h00; m_wdata = 8'h00;
         cur = '0;
      end else begin
         if (q.size() == 0 && !cur.busy && req && cmd != 2'b00) model_accept(cmd, addr, wdata);
         if (q.size() > 0) cur = q.pop_front();
         else              cur = '{1'b0, 1'b0, 3'b000, m_rdata, m_err};
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_en && nreset) begin
         check("busy", busy, cur.busy);
         check("done", done, cur.done);
         check("ee_ctrl", ee_ctrl, {1'b0, cur.ctrl});
         check("rdata", rdata, cur.rdata);
         check("err", err, cur.err);
         check("ee_addr", ee_addr, m_addr);
         check("ee_wdata", ee_wdata, m_wdata);
      end
   end

   // Per-run records, cycle index k counted from the accept edge.
   int er_first, er_last, wr_first, wr_last, rd_first, rd_last, done_cnt, done_cyc, addr_bad;
   logic [7:0] rdata_hist [32];
   logic       err_hist [32];
   logic [3:0] ctrl_hist [32];

   task automatic issue(input logic [1:0] c, input logic [7:0] a, input logic [7:0] d, input int ncyc);
      er_first = -1; er_last = -1; wr_first = -1; wr_last = -1; rd_first = -1; rd_last = -1;
      done_cnt = 0; done_cyc = -1; addr_bad = 0;
      @(negedge clk);
      req = 1'b1; cmd = c; addr = a; wdata = d;
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         if (k == 1) begin req = 1'b0; cmd = 2'b00; end
         if (ee_ctrl[2]) begin if (er_first < 0) er_first = k; er_last = k; end
         if (ee_ctrl[0]) begin if (wr_first < 0) wr_first = k; wr_last = k; end
         if (ee_ctrl[1]) begin if (rd_first < 0) rd_first = k; rd_last = k; end
         if (done) begin done_cnt++; done_cyc = k; end
         if (ee_addr != a || ee_wdata != d) addr_bad++;
         rdata_hist[k] = rdata;
         err_hist[k]   = err;
         ctrl_hist[k]  = ee_ctrl;
      end
   endtask

   task automatic preload(input logic [7:0] a, input logic [7:0] v);
      mem[a] = v;
      ref_mem[a] = v;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int dn;
      int dcyc;
      repeat (3) @(negedge clk);
      nreset = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_rdata", rdata, 8'h00);
      check("reset_ctrl", ee_ctrl, 4'h0);

      // PROGRAM 0xA5 @ 0x3C
      issue(2'b10, 8'h3C, 8'hA5, 16);
      check("prog_erase_first", er_first, 2);
      check("prog_erase_last", er_last, 5);
      check("prog_gap_ctrl", ctrl_hist[6], 4'h0);
      check("prog_wr_first", wr_first, 7);
      check("prog_wr_last", wr_last, 10);
      check("prog_rd_first", rd_first, EXP_PROG_RD);
      check("prog_done_cnt", done_cnt, 1);
      check("prog_done_cyc", done_cyc, EXP_PROG_DONE);
      check("prog_addr_stable", addr_bad, 0);

      // READ of preloaded 0x5A
      preload(8'h3C, 8'h5A);
      issue(2'b01, 8'h3C, 8'h00, 6);
      check("read_rd_first", rd_first, 2);
      check("read_rd_last", rd_last, 3);
      check("read_done_cyc", done_cyc, 4);
      check("read_rdata_c4", rdata_hist[4], 8'h5A);
      check("read_rdata_c6", rdata_hist[6], 8'h5A);

      // ERASE only
      issue(2'b11, 8'h10, 8'h00, 8);
      check("erase_first", er_first, 2);
      check("erase_last", er_last, 5);
      check("erase_no_wr", wr_first, -1);
      check("erase_no_rd", rd_first, -1);
      check("erase_done_cyc", done_cyc, 6);
      check("erase_keeps_rdata", rdata_hist[8], 8'h5A);

      // Collisions: req held through busy and DONE, then accepted on first IDLE cycle
      dn = 0; dcyc = -1;
      @(negedge clk);
      req = 1'b1; cmd = 2'b11; addr = 8'h10; wdata = 8'h00;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (done) begin dn++; dcyc = k; end
         if (k == 1) begin cmd = 2'b01; addr = 8'h77; end
         if (k == 6) check("coll_addr_done", ee_addr, 8'h10);
         if (k == 7) begin check("coll_idle_busy", busy, 1'b0); addr = 8'h3C; end
      end
      check("coll_one_done", dn, 1);
      check("coll_done_cyc", dcyc, 6);
      @(negedge clk);
      req = 1'b0; cmd = 2'b00;
      check("coll_accept_busy", busy, 1'b1);
      check("coll_accept_addr", ee_addr, 8'h3C);
      repeat (6) @(negedge clk);
      check("coll_read_data", rdata, 8'h5A);

      // NOP requests never raise busy
      req = 1'b1; cmd = 2'b00; addr = 8'h99;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("nop_busy", busy, 1'b0);
      end
      req = 1'b0;
      check("nop_addr", ee_addr, 8'h3C);

      // Reset during ERASE (cycle 3)
      @(negedge clk);
      req = 1'b1; cmd = 2'b11; addr = 8'h10; wdata = 8'h00;
      @(negedge clk);
      req = 1'b0; cmd = 2'b00;
      @(negedge clk);
      @(posedge clk);
      #1;
      check("abort_pre_erase", ee_ctrl, 4'b0100);
      chk_en = 1'b0;
      nreset = 1'b0;
      #1;
      check("abort_ctrl", ee_ctrl, 4'h0);
      check("abort_busy", busy, 1'b0);
      repeat (2) @(negedge clk);
      nreset = 1'b1;
      chk_en = 1'b1;
      dn = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done) dn++;
      end
      check("abort_no_done", dn, 0);
      check("abort_rdata", rdata, 8'h00);
      check("abort_idle", busy, 1'b0);

`ifdef EE_SEQ_VERIFY_EN
      // Verify path with a stuck bit in the array
      wr_mask = 8'hFE;
      issue(2'b10, 8'h3C, 8'hA5, 16);
      check("ver_done_cyc", done_cyc, 14);
      check("ver_rdata", rdata_hist[14], 8'hA4);
      check("ver_err", err_hist[14], 1'b1);
      check("ver_err_sticky", err_hist[16], 1'b1);
      wr_mask = 8'hFF;
      repeat (3) @(negedge clk);
      check("ver_err_hold", err, 1'b1);
      issue(2'b01, 8'h3C, 8'h00, 6);
      check("ver_err_clr", err_hist[1], 1'b0);
      check("ver_read_back", rdata_hist[4], 8'hA4);
`endif

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
